// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the memory model and mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);

  // cache-side requests
  logic [1:0]      proc2Imem_command;
  logic [XLEN-1:0] proc2Imem_addr;
  logic [1:0]      proc2Dmem_command;
  logic [XLEN-1:0] proc2Dmem_addr;
  logic [63:0]     proc2Dmem_data;
  logic [1:0]      proc2Dmem_size;

  // memory-side responses
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  // arbitrated command to memory
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [1:0]      proc2mem_size;

  // routed responses back to each cache
  logic [3:0]      Imem2proc_response;
  logic [63:0]     Imem2proc_data;
  logic [3:0]      Imem2proc_tag;
  logic [3:0]      Dmem2proc_response;
  logic [63:0]     Dmem2proc_data;
  logic [3:0]      Dmem2proc_tag;

  // status
  logic            grant_d;
  logic [3:0]      outstanding_loads;
  logic            tag_err;

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    output grant_d, outstanding_loads, tag_err
  );

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    input  grant_d, outstanding_loads, tag_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-way memory bus arbiter (icache/dcache) with dcache priority, icache
// starvation relief, and a per-tag owner table for routing load returns.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;
  localparam logic [1:0] SIZE_DOUBLE = 2'h3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2
  } grant_e;

  grant_e     grant;
  logic       i_req;
  logic       d_req;
  logic [1:0] granted_cmd;
  logic       accepted;
  logic       acc_load;
  logic       ret_hit;
  logic       ret_orphan;
  logic       ret_owner_d;

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic [15:0] pend;
  logic [15:0] pend_next;
  logic [15:0] own;
  logic [15:0] own_next;
  logic        tag_err_q;
  logic        tag_err_next;
  logic [3:0]  pend_count;

  assign i_req = (bus.proc2Imem_command != CMD_NONE);
  assign d_req = (bus.proc2Dmem_command != CMD_NONE);

  // Reset gates the grant so every routed output reads idle during reset.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (d_req && !(i_req && (starve_cnt == LIMIT))) begin
        grant = GRANT_D;
      end else if (i_req) begin
        grant = GRANT_I;
      end
    end
  end

  always_comb begin
    bus.proc2mem_command   = CMD_NONE;
    bus.proc2mem_addr      = '0;
    bus.proc2mem_data      = '0;
    bus.proc2mem_size      = 2'd0;
    bus.Imem2proc_response = 4'd0;
    bus.Dmem2proc_response = 4'd0;
    granted_cmd            = CMD_NONE;
    case (grant)
      GRANT_D: begin
        granted_cmd            = bus.proc2Dmem_command;
        bus.proc2mem_command   = bus.proc2Dmem_command;
        bus.proc2mem_addr      = bus.proc2Dmem_addr;
        bus.proc2mem_data      = bus.proc2Dmem_data;
        bus.proc2mem_size      = bus.proc2Dmem_size;
        bus.Dmem2proc_response = bus.mem2proc_response;
      end
      GRANT_I: begin
        granted_cmd            = bus.proc2Imem_command;
        bus.proc2mem_command   = bus.proc2Imem_command;
        bus.proc2mem_addr      = bus.proc2Imem_addr;
        bus.proc2mem_size      = SIZE_DOUBLE;
        bus.Imem2proc_response = bus.mem2proc_response;
      end
      default: begin
      end
    endcase
  end

  assign accepted = (grant != GRANT_NONE) && (bus.mem2proc_response != 4'd0);
  assign acc_load = accepted && (granted_cmd == CMD_LOAD);

  assign ret_hit     = !reset && (bus.mem2proc_tag != 4'd0) && pend[bus.mem2proc_tag];
  assign ret_orphan  = !reset && (bus.mem2proc_tag != 4'd0) && !pend[bus.mem2proc_tag];
  assign ret_owner_d = own[bus.mem2proc_tag];

  always_comb begin
    bus.Imem2proc_tag = 4'd0;
    bus.Dmem2proc_tag = 4'd0;
    if (ret_hit) begin
      if (ret_owner_d) begin
        bus.Dmem2proc_tag = bus.mem2proc_tag;
      end else begin
        bus.Imem2proc_tag = bus.mem2proc_tag;
      end
    end
  end

  assign bus.Imem2proc_data = bus.mem2proc_data;
  assign bus.Dmem2proc_data = bus.mem2proc_data;

  // A tag being freed by a return in the same cycle is not a duplicate issue.
  always_comb begin
    pend_next    = pend;
    own_next     = own;
    tag_err_next = tag_err_q | ret_orphan;
    if (ret_hit) begin
      pend_next[bus.mem2proc_tag] = 1'b0;
    end
    if (acc_load) begin
      if (pend[bus.mem2proc_response] &&
          !(ret_hit && (bus.mem2proc_tag == bus.mem2proc_response))) begin
        tag_err_next = 1'b1;
      end
      pend_next[bus.mem2proc_response] = 1'b1;
      own_next[bus.mem2proc_response]  = (grant == GRANT_D);
    end
    pend_next[0] = 1'b0;
    own_next[0]  = 1'b0;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (!i_req) begin
      starve_next = 4'd0;
    end else if ((grant == GRANT_I) && accepted) begin
      starve_next = 4'd0;
    end else if ((grant == GRANT_D) && accepted && (starve_cnt < LIMIT)) begin
      starve_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= '0;
      own        <= '0;
      starve_cnt <= 4'd0;
      tag_err_q  <= 1'b0;
    end else begin
      pend       <= pend_next;
      own        <= own_next;
      starve_cnt <= starve_next;
      tag_err_q  <= tag_err_next;
    end
  end

  always_comb begin
    pend_count = 4'd0;
    for (int k = 1; k < 16; k++) begin
      pend_count = pend_count + 4'(pend[k]);
    end
  end

  assign bus.outstanding_loads = pend_count;
  assign bus.tag_err           = tag_err_q;
  assign bus.grant_d           = (grant == GRANT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change 1ns after the
// rising edge, outputs are checked mid-cycle with immediate assertions.
module tb_mem_arbiter;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(
    input logic        rst,
    input logic [1:0]  icmd,
    input logic [31:0] iaddr,
    input logic [1:0]  dcmd,
    input logic [31:0] daddr,
    input logic [63:0] ddata,
    input logic [1:0]  dsize,
    input logic [3:0]  resp,
    input logic [3:0]  rtag,
    input logic [63:0] rdata
  );
    @(posedge clock);
    #1;
    reset                 = rst;
    bus.proc2Imem_command = icmd;
    bus.proc2Imem_addr    = iaddr;
    bus.proc2Dmem_command = dcmd;
    bus.proc2Dmem_addr    = daddr;
    bus.proc2Dmem_data    = ddata;
    bus.proc2Dmem_size    = dsize;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rtag;
    bus.mem2proc_data     = rdata;
    #4;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd0, 64'h0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  initial begin : stimulus
    logic [9:0] seq_d;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.proc2Imem_command = 2'd0;
    bus.proc2Imem_addr    = 32'h0;
    bus.proc2Dmem_command = 2'd0;
    bus.proc2Dmem_addr    = 32'h0;
    bus.proc2Dmem_data    = 64'h0;
    bus.proc2Dmem_size    = 2'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
    bus.mem2proc_data     = 64'h0;

    // Basic dcache load then return
    idle(1'b1);
    idle(1'b1);
    checkOutput("rst_cmd", 64'(bus.proc2mem_command), 64'd0);
    checkOutput("rst_outstanding", 64'(bus.outstanding_loads), 64'd0);
    checkOutput("rst_tag_err", 64'(bus.tag_err), 64'd0);
    checkOutput("rst_grant_d", 64'(bus.grant_d), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd1, 32'h100, 64'h0, 2'd2, 4'd3, 4'd0, 64'h0);
    checkOutput("t1_cmd", 64'(bus.proc2mem_command), 64'd1);
    checkOutput("t1_addr", 64'(bus.proc2mem_addr), 64'h100);
    checkOutput("t1_size", 64'(bus.proc2mem_size), 64'd2);
    checkOutput("t1_dresp", 64'(bus.Dmem2proc_response), 64'd3);
    checkOutput("t1_iresp", 64'(bus.Imem2proc_response), 64'd0);
    checkOutput("t1_grant_d", 64'(bus.grant_d), 64'd1);
    idle(1'b0);
    checkOutput("t1_outstanding1", 64'(bus.outstanding_loads), 64'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd3, 64'hDEAD_BEEF);
    checkOutput("t1_dtag", 64'(bus.Dmem2proc_tag), 64'd3);
    checkOutput("t1_itag", 64'(bus.Imem2proc_tag), 64'd0);
    checkOutput("t1_ddata", bus.Dmem2proc_data, 64'hDEAD_BEEF);
    checkOutput("t1_idata", bus.Imem2proc_data, 64'hDEAD_BEEF);
    idle(1'b0);
    checkOutput("t1_outstanding0", 64'(bus.outstanding_loads), 64'd0);
    checkOutput("t1_tag_err", 64'(bus.tag_err), 64'd0);

    // Fairness: both request every cycle, expect D,D,D,D,I,D,D,D,D,I
    idle(1'b1);
    seq_d = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'd1, 32'h400 + 32'(i), 2'd1, 32'h800 + 32'(i), 64'h0,
                    2'd1, 4'(i + 1), 4'd0, 64'h0);
      checkOutput($sformatf("t2_grant_d_%0d", i), 64'(bus.grant_d), 64'(seq_d[9 - i]));
      checkOutput($sformatf("t2_addr_%0d", i), 64'(bus.proc2mem_addr),
                  seq_d[9 - i] ? 64'(32'h800 + 32'(i)) : 64'(32'h400 + 32'(i)));
      checkOutput($sformatf("t2_iresp_%0d", i), 64'(bus.Imem2proc_response),
                  seq_d[9 - i] ? 64'd0 : 64'(i + 1));
    end
    idle(1'b0);
    checkOutput("t2_outstanding", 64'(bus.outstanding_loads), 64'd10);

    // icache load tag 5, dcache store tag 6; stores are not recorded
    idle(1'b1);
    applyStimulus(1'b0, 2'd1, 32'h200, 2'd0, 32'h0, 64'h0, 2'd0, 4'd5, 4'd0, 64'h0);
    checkOutput("t3_iresp", 64'(bus.Imem2proc_response), 64'd5);
    checkOutput("t3_isize", 64'(bus.proc2mem_size), 64'd3);
    checkOutput("t3_idata0", bus.proc2mem_data, 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd2, 32'h300, 64'h1234, 2'd3, 4'd6, 4'd0, 64'h0);
    checkOutput("t3_store_cmd", 64'(bus.proc2mem_command), 64'd2);
    checkOutput("t3_store_data", bus.proc2mem_data, 64'h1234);
    checkOutput("t3_dresp", 64'(bus.Dmem2proc_response), 64'd6);
    idle(1'b0);
    checkOutput("t3_outstanding", 64'(bus.outstanding_loads), 64'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd6, 64'h66);
    checkOutput("t3_tag6_i", 64'(bus.Imem2proc_tag), 64'd0);
    checkOutput("t3_tag6_d", 64'(bus.Dmem2proc_tag), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd5, 64'h55);
    checkOutput("t3_tag_err", 64'(bus.tag_err), 64'd1);
    checkOutput("t3_tag5_i", 64'(bus.Imem2proc_tag), 64'd5);
    checkOutput("t3_tag5_d", 64'(bus.Dmem2proc_tag), 64'd0);
    idle(1'b0);
    checkOutput("t3_outstanding0", 64'(bus.outstanding_loads), 64'd0);

    // Rejects must not advance the starvation counter
    idle(1'b1);
    applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd1, 4'd0, 64'h0);
    applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd2, 4'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd0, 4'd0, 64'h0);
      checkOutput($sformatf("t4_rej_grant_d_%0d", i), 64'(bus.grant_d), 64'd1);
      checkOutput($sformatf("t4_rej_outstanding_%0d", i), 64'(bus.outstanding_loads), 64'd2);
    end
    applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd7, 4'd0, 64'h0);
    checkOutput("t4_acc_grant_d", 64'(bus.grant_d), 64'd1);
    checkOutput("t4_acc_dresp", 64'(bus.Dmem2proc_response), 64'd7);
    applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd8, 4'd0, 64'h0);
    checkOutput("t4_outstanding3", 64'(bus.outstanding_loads), 64'd3);
    checkOutput("t4_grant_d_4th", 64'(bus.grant_d), 64'd1);
    applyStimulus(1'b0, 2'd1, 32'h10, 2'd1, 32'h20, 64'h0, 2'd0, 4'd0, 4'd0, 64'h0);
    checkOutput("t4_forced_i", 64'(bus.grant_d), 64'd0);

    // Same-cycle return and re-acceptance of tag 9
    idle(1'b1);
    applyStimulus(1'b0, 2'd1, 32'h900, 2'd0, 32'h0, 64'h0, 2'd0, 4'd9, 4'd0, 64'h0);
    idle(1'b0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd1, 32'h990, 64'h0, 2'd0, 4'd9, 4'd9, 64'h99);
    checkOutput("t5_itag", 64'(bus.Imem2proc_tag), 64'd9);
    checkOutput("t5_dtag", 64'(bus.Dmem2proc_tag), 64'd0);
    checkOutput("t5_dresp", 64'(bus.Dmem2proc_response), 64'd9);
    idle(1'b0);
    checkOutput("t5_outstanding", 64'(bus.outstanding_loads), 64'd1);
    checkOutput("t5_tag_err", 64'(bus.tag_err), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd9, 64'h0);
    checkOutput("t5_new_owner_d", 64'(bus.Dmem2proc_tag), 64'd9);
    checkOutput("t5_new_owner_i", 64'(bus.Imem2proc_tag), 64'd0);

    // Reset with loads pending drops them; late return flags tag_err
    idle(1'b1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 2'd1, 32'(i), 64'h0, 2'd0, 4'(i), 4'd0, 64'h0);
    end
    idle(1'b0);
    checkOutput("t6_outstanding3", 64'(bus.outstanding_loads), 64'd3);
    applyStimulus(1'b1, 2'd0, 32'h0, 2'd1, 32'h44, 64'h0, 2'd0, 4'd4, 4'd0, 64'h0);
    checkOutput("t6_rst_cmd", 64'(bus.proc2mem_command), 64'd0);
    checkOutput("t6_rst_dresp", 64'(bus.Dmem2proc_response), 64'd0);
    checkOutput("t6_rst_grant_d", 64'(bus.grant_d), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 2'd0, 4'd0, 4'd2, 64'h0);
    checkOutput("t6_outstanding0", 64'(bus.outstanding_loads), 64'd0);
    checkOutput("t6_itag", 64'(bus.Imem2proc_tag), 64'd0);
    checkOutput("t6_dtag", 64'(bus.Dmem2proc_tag), 64'd0);
    idle(1'b0);
    checkOutput("t6_tag_err", 64'(bus.tag_err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
